// File: rtl/ifetch_unit.sv
// ifetch_unit: instruction-fetch front end for the miniRV core.
// Holds the PC and issues one IROM word request per instruction. It presents the
// fetched word and its decode fields, then waits for execute to retire the
// instruction. The next PC is taken from npc_op/imm/alu_c/branch_taken.
//
// Ports
//   clk, rst_n              core clock, asynchronous active-low reset
//   irom_req, irom_addr     one-cycle fetch strobe and word address (pc[IROM_AW+1:2])
//   irom_rvalid, irom_rdata read data return, accepted only while waiting for it
//   inst_valid, inst        presented instruction (registered)
//   opcode/funct3/funct7    decode fields, combinational from inst
//   pc, pc4                 PC of presented instruction and pc+4 (pc4 combinational)
//   ex_done                 execute retires the presented instruction this cycle
//   npc_op                  00 PC4, 01 JMPR, 10 BEQ, 11 JMP
//   branch_taken, imm, alu_c  next-PC operands
//   misalign_err, bad_target  sticky misaligned-target error and offending target
//   retire_cnt              retired-instruction counter (wraps)
module ifetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned IROM_AW  = 14
) (
  input  logic               clk,
  input  logic               rst_n,
  output logic               irom_req,
  output logic [IROM_AW-1:0] irom_addr,
  input  logic               irom_rvalid,
  input  logic [31:0]        irom_rdata,
  output logic               inst_valid,
  output logic [31:0]        inst,
  output logic [6:0]         opcode,
  output logic [2:0]         funct3,
  output logic [6:0]         funct7,
  output logic [31:0]        pc,
  output logic [31:0]        pc4,
  input  logic               ex_done,
  input  logic [1:0]         npc_op,
  input  logic               branch_taken,
  input  logic [31:0]        imm,
  input  logic [31:0]        alu_c,
  output logic               misalign_err,
  output logic [31:0]        bad_target,
  output logic [31:0]        retire_cnt
);

  typedef enum logic [1:0] {
    S_FETCH,
    S_WAIT,
    S_ISSUE,
    S_HALT
  } state_e;

  state_e             state_q;
  logic [31:0]        pc_q;
  logic [31:0]        inst_q;
  logic               req_q;
  logic [IROM_AW-1:0] addr_q;
  logic               valid_q;
  logic               err_q;
  logic [31:0]        bad_q;
  logic [31:0]        cnt_q;
  logic [31:0]        npc_d;

  // Next-PC selection; 32-bit adds, carries dropped.
  always_comb begin
    npc_d = pc_q + 32'd4;
    case (npc_op)
      2'b01:   npc_d = alu_c & ~32'h1;
      2'b10:   if (branch_taken) npc_d = pc_q + imm;
      2'b11:   npc_d = pc_q + imm;
      default: npc_d = pc_q + 32'd4;
    endcase
  end

  // The request strobe is registered, so it is raised on the edge that enters
  // FETCH from ISSUE. Only after reset does FETCH spend one extra cycle raising it.
  // This keeps zero-wait throughput at FETCH/WAIT/ISSUE = 3 cycles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_FETCH;
      pc_q    <= RESET_PC;
      inst_q  <= 32'h0000_0013;
      req_q   <= 1'b0;
      addr_q  <= '0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
      bad_q   <= '0;
      cnt_q   <= '0;
    end else begin
      case (state_q)
        S_FETCH: begin
          if (req_q) begin
            req_q   <= 1'b0;
            state_q <= S_WAIT;
          end else begin
            req_q  <= 1'b1;
            addr_q <= pc_q[IROM_AW+1:2];
          end
        end
        S_WAIT: begin
          if (irom_rvalid) begin
            inst_q  <= irom_rdata;
            valid_q <= 1'b1;
            state_q <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          if (ex_done) begin
            valid_q <= 1'b0;
            cnt_q   <= cnt_q + 32'd1;
            if (npc_d[1:0] != 2'b00) begin
              err_q   <= 1'b1;
              bad_q   <= npc_d;
              state_q <= S_HALT;
            end else begin
              pc_q    <= npc_d;
              req_q   <= 1'b1;
              addr_q  <= npc_d[IROM_AW+1:2];
              state_q <= S_FETCH;
            end
          end
        end
        S_HALT: begin
          state_q <= S_HALT;
        end
        default: state_q <= S_HALT;
      endcase
    end
  end

  assign irom_req     = req_q;
  assign irom_addr    = addr_q;
  assign inst_valid   = valid_q;
  assign inst         = inst_q;
  assign opcode       = inst_q[6:0];
  assign funct3       = inst_q[14:12];
  assign funct7       = inst_q[31:25];
  assign pc           = pc_q;
  assign pc4          = pc_q + 32'd4;
  assign misalign_err = err_q;
  assign bad_target   = bad_q;
  assign retire_cnt   = cnt_q;

endmodule

// File: tb/tb_ifetch_unit.sv
// Self-checking bench for ifetch_unit.
// A scoreboard queue holds the expected {pc, retire count} of each instruction to be
// presented. A monitor pops and compares an entry whenever inst_valid rises. The
// IROM content is a fixed function of the word address, so the expected instruction
// follows from the expected pc.
module tb_ifetch_unit;
  localparam int unsigned AW = 14;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          irom_req;
  logic [AW-1:0] irom_addr;
  logic          irom_rvalid;
  logic [31:0]   irom_rdata;
  logic          inst_valid;
  logic [31:0]   inst;
  logic [6:0]    opcode;
  logic [2:0]    funct3;
  logic [6:0]    funct7;
  logic [31:0]   pc;
  logic [31:0]   pc4;
  logic          ex_done;
  logic [1:0]    npc_op;
  logic          branch_taken;
  logic [31:0]   imm;
  logic [31:0]   alu_c;
  logic          misalign_err;
  logic [31:0]   bad_target;
  logic [31:0]   retire_cnt;

  always #5 clk = ~clk;

  ifetch_unit #(.RESET_PC(32'h0000_0000), .IROM_AW(AW)) dut (
    .clk(clk), .rst_n(rst_n),
    .irom_req(irom_req), .irom_addr(irom_addr),
    .irom_rvalid(irom_rvalid), .irom_rdata(irom_rdata),
    .inst_valid(inst_valid), .inst(inst),
    .opcode(opcode), .funct3(funct3), .funct7(funct7),
    .pc(pc), .pc4(pc4),
    .ex_done(ex_done), .npc_op(npc_op), .branch_taken(branch_taken),
    .imm(imm), .alu_c(alu_c),
    .misalign_err(misalign_err), .bad_target(bad_target), .retire_cnt(retire_cnt)
  );

  typedef struct {
    logic [31:0] pc;
    logic [31:0] cnt;
  } exp_t;

  exp_t        exp_q[$];
  int          checks = 0;
  int          failures = 0;
  int          cyc = 0;
  int          last_ret_cyc = 0;
  logic [31:0] m_pc;
  logic [31:0] m_cnt;
  logic [31:0] m_bad;
  bit          m_halt;
  int          irom_delay = 0;
  bit          irom_rand = 1'b0;
  bit          ex_noise = 1'b0;
  bit          prev_v = 1'b0;

  always @(posedge clk) cyc++;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%08h required=0x%08h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] rom_word(input logic [AW-1:0] a);
    if (a == '0) return 32'h0050_0093;
    return (32'(a) * 32'h9E37_79B1) ^ 32'h0000_0013;
  endfunction

  // Next-PC rules stated directly from the instruction semantics.
  function automatic logic [31:0] ref_npc(input logic [31:0] p, input logic [1:0] op,
                                          input logic tk, input logic [31:0] im,
                                          input logic [31:0] ac);
    case (op)
      2'd0:    return p + 32'd4;
      2'd1:    return {ac[31:1], 1'b0};
      2'd2:    return tk ? p + im : p + 32'd4;
      default: return p + im;
    endcase
  endfunction

  // Monitor: compare each newly presented instruction against the scoreboard.
  initial begin : monitor
    exp_t        e;
    logic [31:0] w;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        prev_v = 1'b0;
      end else begin
        if (inst_valid && !prev_v) begin
          if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_issue actual_pc=0x%08h required=no presentation", pc);
          end else begin
            e = exp_q.pop_front();
            w = rom_word(e.pc[AW+1:2]);
            chk("pc", pc, e.pc);
            chk("inst", inst, w);
            chk("opcode", 32'(opcode), 32'(w[6:0]));
            chk("funct3", 32'(funct3), 32'(w[14:12]));
            chk("funct7", 32'(funct7), 32'(w[31:25]));
            chk("pc4", pc4, e.pc + 32'd4);
            chk("retire_cnt", retire_cnt, e.cnt);
          end
        end
        prev_v = inst_valid;
      end
    end
  end

  // IROM model: answer each request after a configurable number of extra wait cycles.
  initial begin : irom
    logic [AW-1:0] ra;
    int            d;
    bit            ok;
    irom_rvalid = 1'b0;
    irom_rdata  = '0;
    forever begin
      @(negedge clk);
      if (rst_n && irom_req) begin
        ra = irom_addr;
        d  = irom_rand ? int'($urandom_range(0, 3)) : irom_delay;
        ok = 1'b1;
        for (int k = 0; k < d && ok; k++) begin
          @(posedge clk);
          #1;
          if (!rst_n) ok = 1'b0;
          else chk("iv_before_rvalid", 32'(inst_valid), 32'h0);
        end
        if (ok) begin
          @(posedge clk);
          #1;
          if (!rst_n) ok = 1'b0;
        end
        if (ok) begin
          irom_rvalid = 1'b1;
          irom_rdata  = rom_word(ra);
          @(posedge clk);
          #1;
          irom_rvalid = 1'b0;
          irom_rdata  = $urandom;
        end
      end
    end
  end

  task automatic check_reset_vals(input string tag);
    chk({tag, "_req"}, 32'(irom_req), 32'h0);
    chk({tag, "_valid"}, 32'(inst_valid), 32'h0);
    chk({tag, "_inst"}, inst, 32'h0000_0013);
    chk({tag, "_opcode"}, 32'(opcode), 32'h13);
    chk({tag, "_pc"}, pc, 32'h0);
    chk({tag, "_pc4"}, pc4, 32'h4);
    chk({tag, "_err"}, 32'(misalign_err), 32'h0);
    chk({tag, "_bad"}, bad_target, 32'h0);
    chk({tag, "_cnt"}, retire_cnt, 32'h0);
  endtask

  task automatic do_reset(input bit startup);
    rst_n   = 1'b0;
    ex_done = 1'b0;
    exp_q.delete();
    m_pc   = 32'h0;
    m_cnt  = 32'h0;
    m_halt = 1'b0;
    #1;
    if (!startup) check_reset_vals("rst_async");
    repeat (3) @(negedge clk);
    check_reset_vals("rst");
    rst_n = 1'b1;
    exp_q.push_back('{32'h0, 32'h0});
  endtask

  task automatic run_instr(input logic [1:0] op, input logic tk, input logic [31:0] im,
                           input logic [31:0] ac, input int exwait);
    int          n = 0;
    logic [31:0] npc;
    @(negedge clk);
    while (!inst_valid && n < 60) begin
      if (ex_noise) begin
        ex_done      = 1'($urandom_range(0, 1));
        npc_op       = 2'($urandom_range(0, 3));
        branch_taken = 1'($urandom_range(0, 1));
        imm          = $urandom;
        alu_c        = $urandom;
      end
      @(negedge clk);
      n++;
    end
    ex_done = 1'b0;
    if (!inst_valid) begin
      checks++;
      failures++;
      $display("FAIL issue_timeout actual=no inst_valid required=inst_valid within 60 cycles");
      return;
    end
    for (int i = 0; i < exwait; i++) begin
      chk("hold_pc", pc, m_pc);
      chk("hold_inst", inst, rom_word(m_pc[AW+1:2]));
      chk("hold_valid", 32'(inst_valid), 32'h1);
      @(negedge clk);
    end
    npc_op       = op;
    branch_taken = tk;
    imm          = im;
    alu_c        = ac;
    ex_done      = 1'b1;
    npc          = ref_npc(m_pc, op, tk, im, ac);
    m_cnt        = m_cnt + 32'd1;
    last_ret_cyc = cyc;
    if (npc[1:0] != 2'b00) begin
      m_halt = 1'b1;
      m_bad  = npc;
    end else begin
      m_pc = npc;
      exp_q.push_back('{npc, m_cnt});
    end
    @(posedge clk);
    #1;
    ex_done = 1'b0;
  endtask

  task automatic run_random(input int count);
    logic [31:0] ri;
    logic [31:0] ra;
    for (int i = 0; i < count; i++) begin
      ri = (32'($urandom_range(0, 511)) << 2) - 32'd1024;
      ra = ($urandom & 32'hFFFF_FFFC) | 32'($urandom_range(0, 1));
      run_instr(2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), ri, ra,
                int'($urandom_range(0, 2)));
    end
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog actual=timeout required=finish before 500000");
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    int prev_ret;
    int nreq;
    rst_n        = 1'b0;
    ex_done      = 1'b0;
    npc_op       = 2'b00;
    branch_taken = 1'b0;
    imm          = '0;
    alu_c        = '0;

    do_reset(1'b1);
    @(negedge clk);
    chk("t1_first_req", 32'(irom_req), 32'h1);
    chk("t1_first_addr", 32'(irom_addr), 32'h0);

    for (int i = 0; i < 4; i++) begin
      prev_ret = last_ret_cyc;
      run_instr(2'b00, 1'b0, 32'h0, 32'h0, 0);
      if (i > 0) chk("t2_cycles_per_instr", 32'(last_ret_cyc - prev_ret), 32'd3);
    end
    @(negedge clk);
    chk("t2_retire_cnt", retire_cnt, 32'd4);

    irom_delay = 3;
    run_instr(2'b10, 1'b1, 32'hFFFF_FFF8, $urandom, 2);
    irom_delay = 0;
    run_instr(2'b11, 1'b0, 32'h0000_0008, $urandom, 0);
    run_instr(2'b10, 1'b0, 32'hFFFF_FFF8, $urandom, 1);
    run_instr(2'b10, 1'b1, 32'hFFFF_FFF4, $urandom, 0);
    run_instr(2'b11, 1'b1, 32'h0000_0100, $urandom, 0);

    run_instr(2'b01, 1'b0, $urandom, 32'h0000_0201, 0);
    run_instr(2'b01, 1'b0, $urandom, 32'h0000_0202, 0);
    nreq = 0;
    for (int i = 0; i < 20; i++) begin
      ex_done = 1'b1;
      npc_op  = 2'b00;
      @(negedge clk);
      if (irom_req) nreq++;
    end
    ex_done = 1'b0;
    chk("t5_halt_no_req", 32'(nreq), 32'h0);
    chk("t5_err", 32'(misalign_err), 32'h1);
    chk("t5_bad_target", bad_target, 32'h0000_0202);
    chk("t5_model_bad", bad_target, m_bad);
    chk("t5_halt_pc", pc, 32'h0000_0200);
    chk("t5_halt_valid", 32'(inst_valid), 32'h0);
    chk("t5_halt_cnt", retire_cnt, m_cnt);
    chk("t5_halt_inst", inst, rom_word(14'h0080));

    do_reset(1'b1);
    run_random(5);
    irom_delay = 6;
    nreq = 0;
    while (!irom_req && nreq < 20) begin
      @(negedge clk);
      nreq++;
    end
    chk("t6_req_seen", 32'(irom_req), 32'h1);
    @(posedge clk);
    #2;
    chk("t6_cnt_before", retire_cnt, 32'd5);
    do_reset(1'b0);
    irom_delay = 0;
    @(negedge clk);
    chk("t6_refetch_req", 32'(irom_req), 32'h1);
    chk("t6_refetch_addr", 32'(irom_addr), 32'h0);

    irom_rand = 1'b1;
    ex_noise  = 1'b1;
    run_random(80);
    @(negedge clk);
    chk("final_retire_cnt", retire_cnt, m_cnt);
    chk("final_no_err", 32'(misalign_err), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
